// File: rtl/slp_train.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | slp_train : single-layer perceptron weight trainer (one weight per cycle) |
// | Optional: define SLP_TRAIN_SAT_EN to clamp weight updates and flag sat.   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module slp_train #(
  parameter int IN       = 4,
  parameter int I_PREC   = 8,
  parameter int W_PREC   = 8,
  parameter int O_PREC   = 8,
  parameter int LR_SHIFT = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_load,
  input  logic [(IN+1)*W_PREC-1:0]   w_init,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IN*I_PREC-1:0]       in,
  input  logic [O_PREC-1:0]          target,
  input  logic [O_PREC-1:0]          out,
  output logic [(IN+1)*W_PREC-1:0]   weight,
  output logic                       busy,
  output logic                       done,
  output logic                       sat
);

  localparam int c_IDXW = (IN < 1) ? 1 : $clog2(IN + 1);
  localparam int c_PW   = I_PREC + O_PREC + 1;
  localparam int c_SW   = ((c_PW > W_PREC) ? c_PW : W_PREC) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_UPD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                         r_state;
  logic [IN:0][W_PREC-1:0]        r_w;
  logic [IN-1:0][I_PREC-1:0]      r_in;
  logic signed [O_PREC-1:0]       r_target;
  logic signed [O_PREC-1:0]       r_out;
  logic signed [O_PREC:0]         r_err;
  logic [c_IDXW-1:0]              r_idx;
  logic                           r_done;

  logic signed [O_PREC:0]         w_diff;
  logic [I_PREC-1:0]              w_in_sel;
  logic [W_PREC-1:0]              w_w_sel;
  logic                           w_is_bias;
  logic signed [c_PW-1:0]         w_err_x;
  logic signed [c_PW-1:0]         w_in_x;
  logic signed [c_PW-1:0]         w_prod;
  logic signed [c_PW-1:0]         w_delta;
  logic signed [c_PW-1:0]         w_shift;
  logic signed [c_SW-1:0]         w_cur_x;
  logic signed [c_SW-1:0]         w_shift_x;
  logic signed [c_SW-1:0]         w_sum;
  logic [W_PREC-1:0]              w_new;

  assign w_diff = {r_target[O_PREC-1], r_target} - {r_out[O_PREC-1], r_out};

  // Operand muxes for the weight currently addressed by r_idx
  always_comb begin
    w_in_sel = '0;
    w_w_sel  = '0;
    for (int i = 0; i < IN; i++) begin
      if (r_idx == c_IDXW'(i)) w_in_sel = r_in[i];
    end
    for (int i = 0; i <= IN; i++) begin
      if (r_idx == c_IDXW'(i)) w_w_sel = r_w[i];
    end
  end

  assign w_is_bias = (r_idx == c_IDXW'(IN));
  assign w_err_x   = {{(c_PW-O_PREC-1){r_err[O_PREC]}}, r_err};
  assign w_in_x    = {{(c_PW-I_PREC){w_in_sel[I_PREC-1]}}, w_in_sel};
  assign w_prod    = w_err_x * w_in_x;
  assign w_delta   = w_is_bias ? w_err_x : w_prod;
  assign w_shift   = w_delta >>> LR_SHIFT;
  assign w_cur_x   = {{(c_SW-W_PREC){w_w_sel[W_PREC-1]}}, w_w_sel};
  assign w_shift_x = {{(c_SW-c_PW){w_shift[c_PW-1]}}, w_shift};
  assign w_sum     = w_cur_x + w_shift_x;

`ifdef SLP_TRAIN_SAT_EN
  localparam logic signed [c_SW-1:0] c_WMAX = {{(c_SW-W_PREC+1){1'b0}}, {(W_PREC-1){1'b1}}};
  localparam logic signed [c_SW-1:0] c_WMIN = ~c_WMAX;

  logic w_ovf;
  logic r_sat;

  assign w_ovf = (w_sum > c_WMAX) || (w_sum < c_WMIN);
  assign w_new = !w_ovf ? w_sum[W_PREC-1:0] :
                 (w_sum[c_SW-1] ? c_WMIN[W_PREC-1:0] : c_WMAX[W_PREC-1:0]);
  assign sat   = r_sat;
`else
  logic w_unused_sum;

  // Two's-complement wrap: only the low W_PREC bits of the sum survive
  assign w_new        = w_sum[W_PREC-1:0];
  assign w_unused_sum = ^w_sum[c_SW-1:W_PREC];
  assign sat          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_w      <= '0;
      r_in     <= '0;
      r_target <= '0;
      r_out    <= '0;
      r_err    <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
`ifdef SLP_TRAIN_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_w <= w_init;
`ifdef SLP_TRAIN_SAT_EN
            r_sat <= 1'b0;
`endif
          end else if (req_valid) begin
            r_in     <= in;
            r_target <= target;
            r_out    <= out;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_err <= w_diff;
          r_idx <= '0;
          if (w_diff == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_UPD;
          end
        end
        S_UPD: begin
          for (int i = 0; i <= IN; i++) begin
            if (r_idx == c_IDXW'(i)) r_w[i] <= w_new;
          end
`ifdef SLP_TRAIN_SAT_EN
          if (w_ovf) r_sat <= 1'b1;
`endif
          if (w_is_bias) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) && !w_load;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign weight    = r_w;

endmodule
`default_nettype wire

// File: tb/tb_slp_train.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_slp_train : directed scoreboard bench for slp_train                    |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_slp_train;

  logic        clk = 1'b0;
  logic        reset, w_load, req_valid, req_ready, busy, done, sat;
  logic [39:0] w_init, weight;
  logic [31:0] in_v;
  logic [7:0]  target, out_v;

  logic        rv2, rdy2, busy2, done2, sat2;
  logic [39:0] wi2, w2;
  logic [31:0] in2;
  logic [7:0]  tg2, ot2;

  always #5 clk = ~clk;

  slp_train dut (
    .clk(clk), .reset(reset), .w_load(w_load), .w_init(w_init),
    .req_valid(req_valid), .req_ready(req_ready), .in(in_v), .target(target),
    .out(out_v), .weight(weight), .busy(busy), .done(done), .sat(sat)
  );

  slp_train #(.LR_SHIFT(2)) dut2 (
    .clk(clk), .reset(reset), .w_load(1'b0), .w_init(wi2),
    .req_valid(rv2), .req_ready(rdy2), .in(in2), .target(tg2),
    .out(ot2), .weight(w2), .busy(busy2), .done(done2), .sat(sat2)
  );

  typedef struct {
    logic [39:0] w;
    int          lat;
    bit          s;
  } exp_t;

  exp_t sbq[$];
  int   mw[5];
  bit   msat;
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic narrow8(input int s, output int r);
`ifdef SLP_TRAIN_SAT_EN
    if (s > 127) begin r = 127; msat = 1'b1; end
    else if (s < -128) begin r = -128; msat = 1'b1; end
    else r = s;
`else
    r = s & 255;
    if (r > 127) r = r - 256;
`endif
  endtask

  function automatic logic [39:0] packw();
    logic [39:0] r;
    for (int i = 0; i < 5; i++) r[i*8 +: 8] = 8'(mw[i]);
    return r;
  endfunction

  task automatic setw(input logic [39:0] v);
    for (int i = 0; i < 5; i++) mw[i] = int'($signed(v[i*8 +: 8]));
  endtask

  // Offer a sample in the current cycle and push the model's prediction
  task automatic offer(input logic [31:0] iv, input logic [7:0] tg, input logic [7:0] ot);
    exp_t e;
    int   err, d, r;
    in_v = iv; target = tg; out_v = ot; req_valid = 1'b1;
    #1;
    chk("ready_at_offer", {63'd0, req_ready}, 64'd1);
    err = int'($signed(tg)) - int'($signed(ot));
    if (err != 0) begin
      for (int i = 0; i < 5; i++) begin
        d = (i < 4) ? (err * int'($signed(iv[i*8 +: 8]))) : err;
        narrow8(mw[i] + d, r);
        mw[i] = r;
      end
    end
    e.w = packw(); e.lat = (err == 0) ? 2 : 7; e.s = msat;
    sbq.push_back(e);
  endtask

  task automatic wait_done(input bit load_pulse);
    exp_t e;
    int   n = 0;
    bit   got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        in_v = $urandom; target = 8'($urandom); out_v = 8'($urandom);
        chk("busy_in_calc", {63'd0, busy}, 64'd1);
      end
      if (load_pulse && n == 2) begin w_init = 40'h7F7F7F7F7F; w_load = 1'b1; end
      if (n == 3) w_load = 1'b0;
      if (done) got = 1'b1;
    end
    w_load = 1'b0;
    chk("done_seen", {63'd0, got}, 64'd1);
    if (got && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("done_latency", 64'(n), 64'(e.lat));
      chk("weights", {24'd0, weight}, {24'd0, e.w});
      chk("sat", {63'd0, sat}, {63'd0, e.s});
      chk("busy_in_done", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      chk("done_one_cycle", {63'd0, done}, 64'd0);
      chk("ready_after_done", {63'd0, req_ready}, 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset = 1'b1; w_load = 1'b0; req_valid = 1'b0; w_init = '0;
    in_v = '0; target = '0; out_v = '0;
    rv2 = 1'b0; wi2 = '0; in2 = '0; tg2 = '0; ot2 = '0;
    for (int i = 0; i < 5; i++) mw[i] = 0;
    msat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_weight", {24'd0, weight}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sat", {63'd0, sat}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic update from zero weights
    offer({8'd4, 8'hFD, 8'hFE, 8'd1}, 8'd5, 8'd0);
    wait_done(1'b0);
    chk("basic_literal", {24'd0, weight}, {24'd0, 8'd5, 8'd20, 8'hF1, 8'hF6, 8'd5});

    // Zero error: fast path, no weight change
    offer({8'd9, 8'd9, 8'd9, 8'd9}, 8'd3, 8'd3);
    wait_done(1'b0);

    // Large values with an ignored mid-update w_load
    offer({8'h80, 8'd100, 8'hF8, 8'd7}, 8'h9C, 8'd27);
    wait_done(1'b1);

    // Overflow case on w[0]
    w_init = {8'd0, 8'd0, 8'd0, 8'd0, 8'd120};
    w_load = 1'b1;
    @(posedge clk); #1;
    w_load = 1'b0;
    setw(w_init); msat = 1'b0;
    chk("load_weight", {24'd0, weight}, {24'd0, w_init});
    chk("load_sat_clr", {63'd0, sat}, 64'd0);
    offer(32'h00000004, 8'd5, 8'd0);
    wait_done(1'b0);
`ifdef SLP_TRAIN_SAT_EN
    chk("ovf_w0", {56'd0, weight[7:0]}, 64'd127);
    chk("ovf_sat", {63'd0, sat}, 64'd1);
`else
    chk("ovf_w0", {56'd0, weight[7:0]}, 64'h8C);
    chk("ovf_sat", {63'd0, sat}, 64'd0);
`endif

    // w_load and req_valid together: load wins, sample taken next cycle
    w_init = {8'd1, 8'd5, 8'd4, 8'd3, 8'd2};
    in_v = 32'h01010101; target = 8'hFE; out_v = 8'd1;
    w_load = 1'b1; req_valid = 1'b1;
    #1;
    chk("ready_during_load", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    w_load = 1'b0;
    setw(w_init); msat = 1'b0;
    chk("load_with_valid", {24'd0, weight}, {24'd0, w_init});
    chk("no_accept_on_load", {63'd0, busy}, 64'd0);
    offer(32'h01010101, 8'hFE, 8'd1);
    wait_done(1'b0);

    // Reset in the middle of an update
    offer(32'h01020304, 8'd10, 8'd0);
    sbq.delete();
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) mw[i] = 0;
    msat = 1'b0;
    chk("midrst_weight", {24'd0, weight}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", {63'd0, seen}, 64'd0);

    // Reset has priority over w_load and req_valid
    w_init = 40'h0102030405; w_load = 1'b1; req_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; w_load = 1'b0; req_valid = 1'b0;
    chk("rstprio_weight", {24'd0, weight}, 64'd0);
    chk("rstprio_busy", {63'd0, busy}, 64'd0);
    offer(32'h00FF0102, 8'd50, 8'hF6);
    wait_done(1'b0);

    // Learning-rate shift of 2 on the second instance
    in2 = 32'h00000002; tg2 = 8'hFD; ot2 = 8'd0; rv2 = 1'b1;
    #1;
    chk("lr_ready", {63'd0, rdy2}, 64'd1);
    @(posedge clk); #1;
    rv2 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      if (done2) seen = 1'b1;
    end
    chk("lr_done_seen", {63'd0, seen}, 64'd1);
    chk("lr_w0", {56'd0, w2[7:0]}, 64'hFE);
    chk("lr_mid", {40'd0, w2[31:8]}, 64'd0);
    chk("lr_bias", {56'd0, w2[39:32]}, 64'hFF);
    chk("lr_sat", {63'd0, sat2}, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slp_train.md
SLP_TRAIN -- requirements
Module: slp_train

Interface
REQ-001 Parameter IN, default 4: number of inputs; the weight vector holds IN+1 entries, and entry IN is the bias.
REQ-002 Parameter I_PREC, default 8: signed integer input width.
REQ-003 Parameter W_PREC, default 8: signed integer weight width.
REQ-004 Parameter O_PREC, default 8: signed integer width of target and inference output.
REQ-005 Parameter LR_SHIFT, default 0: learning rate = 2^-LR_SHIFT, applied as an arithmetic right shift.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 w_load  input  1  load w_init into the weight registers.
REQ-009 w_init  input  (IN+1)*W_PREC  initial weight vector, packed [IN:0][W_PREC-1:0].
REQ-010 req_valid  input  1  training sample offered.
REQ-011 req_ready  output  1  sample can be accepted.
REQ-012 in  input  IN*I_PREC  sample inputs, packed [IN-1:0][I_PREC-1:0].
REQ-013 target  input  O_PREC  desired output.
REQ-014 out  input  O_PREC  current slp_infer output for the same sample.
REQ-015 weight  output  (IN+1)*W_PREC  current weights, direct from registers; feeds the slp_infer weight port.
REQ-016 busy  output  1  high in CALC, UPD and DONE.
REQ-017 done  output  1  one-cycle pulse when an update finishes.
REQ-018 sat  output  1  sticky flag: some weight update saturated since the last reset or w_load.

Function
REQ-019 The block SHALL implement the FSM states IDLE, CALC, UPD and DONE.
REQ-020 req_ready SHALL equal (state==IDLE && !w_load).
REQ-021 On req_valid && req_ready the block SHALL register in, target and out, then move to CALC.
REQ-022 In IDLE with w_load high, weight SHALL take w_init at the next edge and sat SHALL clear; w_load in any other state SHALL be ignored.
REQ-023 CALC (1 cycle) SHALL register err = target - out at O_PREC+1 bits signed; if err==0 the next state SHALL be DONE, otherwise UPD with idx=0.
REQ-024 UPD SHALL write one weight per cycle, idx 0..IN; at idx IN it SHALL go to DONE.
REQ-025 For idx<IN the update SHALL be w[idx] += (err*in[idx]) >>> LR_SHIFT; for idx==IN (bias) it SHALL be w[IN] += err >>> LR_SHIFT.
REQ-026 The product SHALL be I_PREC+O_PREC+1 bits signed; the shift SHALL be arithmetic (floor); the sum SHALL be formed at full width before narrowing to W_PREC.
REQ-027 DONE (1 cycle) SHALL assert done, then return to IDLE; a new sample SHALL be accepted no earlier than the cycle after DONE.
REQ-028 Latency with err!=0: accept at cycle 0, CALC at 1, UPD at 2..IN+2, done at cycle IN+3; with err==0, done at cycle 2.
REQ-029 Each weight change SHALL be visible on weight the cycle after its UPD cycle.
REQ-030 Inputs sampled outside the accept cycle SHALL have no effect.

Reset
REQ-031 While reset is high at an edge: state SHALL become IDLE, every weight 0, idx 0, err 0, done 0 and sat 0.
REQ-032 Reset SHALL override any in-progress update mid-operation; the partially updated weights SHALL be discarded (zeroed).
REQ-033 Reset SHALL take priority over w_load and req_valid in the same cycle.

Configuration
REQ-034 Macro SLP_TRAIN_SAT_EN defined: a narrowed sum outside the W_PREC signed range SHALL clamp to max/min and set sat.
REQ-035 Macro SLP_TRAIN_SAT_EN undefined: the sum SHALL wrap (two's-complement truncation) and sat SHALL be tied to 0.

Verification
REQ-036 Default parameters, weights 0, in={1,-2,-3,4}, target=5, out=0 -> weights {5,-10,-15,20}, bias 5, done at cycle 7 after accept, sat=0.
REQ-037 target=out=3 -> done at cycle 2, weights unchanged, no UPD state entered.
REQ-038 SAT_EN defined, w_init w[0]=120, in[0]=4, err=5 -> w[0]=127, sat=1; SAT_EN undefined -> w[0]=-116, sat=0.
REQ-039 LR_SHIFT=2, err=-3, in[0]=2 -> w[0] decrements by 2 (floor of -6/4), bias decrements by 1.
REQ-040 reset asserted at cycle 4 of an update -> next cycle: all weights 0, state IDLE, req_ready=1, no done pulse.
REQ-041 w_load and req_valid high together in IDLE -> w_init loaded, req_ready=0 that cycle, sample accepted the next cycle if req_valid stays high.
